// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 4'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // True when an ID source operand reads the register a load in EX is about to write.
  function automatic logic src_hit(input logic used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] rd);
    return used && (src == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hold/bubble generator for the 5-stage pipeline registers: load-use, branch
// flush, I/D memory waits and HLT drain, plus saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic                  id_branch_taken,
  input  logic                  id_halt,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  ifid_bubble,
  output logic                  idex_hold,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic                  memwb_bubble,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYCLES);

  ctrl_state_t state, nxt_state;
  logic [1:0]  dcnt, nxt_dcnt;
  logic        squash_pending, nxt_squash;
  logic        load_use;
  logic        flush_inc;
  logic        stall_inc;

  assign load_use = idex_memread && (idex_rd != ZERO_REG) &&
                    (src_hit(id_rs_used, id_rs, idex_rd) ||
                     src_hit(id_rt_used, id_rt, idex_rd));

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_bubble  = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    flush_inc    = 1'b0;
    nxt_state    = state;
    nxt_dcnt     = dcnt;
    nxt_squash   = squash_pending;

    case (state)
      RUN: begin
        if (mem_busy) begin
          pc_hold      = 1'b1;
          ifid_hold    = 1'b1;
          idex_hold    = 1'b1;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
        end else if (load_use) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_halt) begin
          pc_hold     = 1'b1;
          ifid_bubble = 1'b1;
          nxt_state   = DRAIN;
          nxt_dcnt    = DRAIN_LOAD;
        end else if (id_branch_taken) begin
          // PC loads the target; a still-busy fetch will deliver a wrong-path word later.
          ifid_bubble = 1'b1;
          flush_inc   = 1'b1;
          if (if_busy) nxt_squash = 1'b1;
        end else if (if_busy) begin
          pc_hold     = 1'b1;
          ifid_bubble = 1'b1;
        end else if (squash_pending) begin
          ifid_bubble = 1'b1;
          nxt_squash  = 1'b0;
        end
      end

      DRAIN: begin
        pc_hold     = 1'b1;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
        if (mem_busy) begin
          idex_hold    = 1'b1;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
        end else begin
          nxt_dcnt = dcnt - 2'd1;
          if (dcnt <= 2'd1) nxt_state = HALTED;
        end
      end

      default: begin
        halted      = 1'b1;
        pc_hold     = 1'b1;
        ifid_bubble = 1'b1;
        idex_bubble = 1'b1;
      end
    endcase

    // While reset is held, park the pipeline on NOPs regardless of state.
    if (!rst) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b0;
      ifid_bubble  = 1'b1;
      idex_hold    = 1'b0;
      idex_bubble  = 1'b1;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b1;
      halted       = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      dcnt           <= 2'd0;
      squash_pending <= 1'b0;
    end else begin
      state          <= nxt_state;
      dcnt           <= nxt_dcnt;
      squash_pending <= nxt_squash;
    end
  end

  assign stall_inc = pc_hold && (state != HALTED);
  assign dbg_state = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors queued per step and checked mid-cycle.
module tb_hazard_ctrl;

  // Output vector: {pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble, exmem_hold, memwb_bubble, halted}
  localparam logic [7:0] O_NONE   = 8'h00;
  localparam logic [7:0] O_FREEZE = 8'hD6;
  localparam logic [7:0] O_LDUSE  = 8'hC8;
  localparam logic [7:0] O_HOLDPC = 8'hA0;
  localparam logic [7:0] O_FLUSH  = 8'h20;
  localparam logic [7:0] O_DRAIN  = 8'hA8;
  localparam logic [7:0] O_DRNMB  = 8'hBE;
  localparam logic [7:0] O_HALTED = 8'hA9;
  localparam logic [7:0] O_RESET  = 8'hAA;

  logic        clk;
  logic        rst;
  logic [3:0]  id_rs, id_rt, idex_rd;
  logic        id_rs_used, id_rt_used, idex_memread;
  logic        id_branch_taken, id_halt, if_busy, mem_busy;
  logic        pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble;
  logic        exmem_hold, memwb_bubble, halted;
  logic [15:0] stall_cycles, flush_count;
  logic [1:0]  dbg_state;

  logic [7:0]  exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .idex_rd         (idex_rd),
    .idex_memread    (idex_memread),
    .id_branch_taken (id_branch_taken),
    .id_halt         (id_halt),
    .if_busy         (if_busy),
    .mem_busy        (mem_busy),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_bubble     (ifid_bubble),
    .idex_hold       (idex_hold),
    .idex_bubble     (idex_bubble),
    .exmem_hold      (exmem_hold),
    .memwb_bubble    (memwb_bubble),
    .halted          (halted),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .dbg_state       (dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic clr();
    id_rs = 4'd0; id_rt = 4'd0; idex_rd = 4'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; idex_memread = 1'b0;
    id_branch_taken = 1'b0; id_halt = 1'b0; if_busy = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    clr();
  endtask

  task automatic load_use_rs(input logic [3:0] r);
    idex_memread = 1'b1; idex_rd = r; id_rs = r; id_rs_used = 1'b1;
  endtask

  // Scoreboard
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check_val(tag, {24'd0, pc_hold, ifid_hold, ifid_bubble, idex_hold, idex_bubble,
                    exmem_hold, memwb_bubble, halted}, {24'd0, e});
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #2;
    step(O_RESET, "reset_outputs");
    check_val("reset_stall", {16'd0, stall_cycles}, 32'd0);
    check_val("reset_flush", {16'd0, flush_count}, 32'd0);
    check_val("reset_state", {30'd0, dbg_state}, 32'd0);

    @(negedge clk); rst = 1'b1;
    step(O_NONE, "idle");

    // Load-use through rs, then rd=0, rt match, and rs match with rs unused
    next_cycle(); load_use_rs(4'd5);
    step(O_LDUSE, "load_use_rs");
    next_cycle();
    step(O_NONE, "load_use_one_cycle");
    check_val("stall_after_lu", {16'd0, stall_cycles}, 32'd1);
    next_cycle(); load_use_rs(4'd0);
    step(O_NONE, "load_use_r0");
    next_cycle(); idex_memread = 1'b1; idex_rd = 4'd9; id_rt = 4'd9; id_rt_used = 1'b1;
    step(O_LDUSE, "load_use_rt");
    next_cycle(); idex_memread = 1'b1; idex_rd = 4'd7; id_rs = 4'd7; id_rs_used = 1'b0;
    step(O_NONE, "rs_unused");
    next_cycle(); idex_rd = 4'd7; id_rs = 4'd7; id_rs_used = 1'b1;
    step(O_NONE, "not_a_load");
    check_val("stall_after_rt", {16'd0, stall_cycles}, 32'd2);

    // Branch flush with fetch ready, then with fetch busy for 3 cycles
    next_cycle(); id_branch_taken = 1'b1;
    step(O_FLUSH, "branch");
    next_cycle();
    step(O_NONE, "branch_one_bubble");
    check_val("flush_1", {16'd0, flush_count}, 32'd1);
    next_cycle(); id_branch_taken = 1'b1; if_busy = 1'b1;
    step(O_FLUSH, "branch_ifbusy_c1");
    next_cycle(); if_busy = 1'b1;
    step(O_HOLDPC, "branch_ifbusy_c2");
    next_cycle(); if_busy = 1'b1;
    step(O_HOLDPC, "branch_ifbusy_c3");
    next_cycle();
    step(O_FLUSH, "squash_bubble");
    next_cycle();
    step(O_NONE, "squash_cleared");
    check_val("flush_2", {16'd0, flush_count}, 32'd2);
    check_val("stall_after_br", {16'd0, stall_cycles}, 32'd4);

    // Memory wait with a simultaneous load-use
    for (int i = 0; i < 4; i++) begin
      next_cycle(); mem_busy = 1'b1; load_use_rs(4'd3);
      step(O_FREEZE, "mem_freeze");
    end
    next_cycle(); load_use_rs(4'd3);
    step(O_LDUSE, "lu_after_mem");
    next_cycle();
    step(O_NONE, "after_mem_idle");
    check_val("stall_after_mem", {16'd0, stall_cycles}, 32'd9);

    // Halt with branch alongside, drain with 2 memory-wait cycles
    next_cycle(); id_halt = 1'b1; id_branch_taken = 1'b1;
    step(O_HOLDPC, "halt_in_id");
    next_cycle(); id_branch_taken = 1'b1; if_busy = 1'b1;
    step(O_DRAIN, "drain_1");
    check_val("drain_state", {30'd0, dbg_state}, 32'd1);
    next_cycle(); mem_busy = 1'b1;
    step(O_DRNMB, "drain_mb_1");
    next_cycle(); mem_busy = 1'b1;
    step(O_DRNMB, "drain_mb_2");
    next_cycle();
    step(O_DRAIN, "drain_2");
    next_cycle(); id_halt = 1'b1;
    step(O_DRAIN, "drain_3");
    next_cycle();
    step(O_HALTED, "halted_rise");
    check_val("stall_at_halt", {16'd0, stall_cycles}, 32'd15);
    check_val("flush_in_halt", {16'd0, flush_count}, 32'd2);
    next_cycle(); mem_busy = 1'b1; load_use_rs(4'd2); id_branch_taken = 1'b1;
    step(O_HALTED, "halted_ignores");
    next_cycle();
    step(O_HALTED, "halted_sticky");
    check_val("stall_frozen", {16'd0, stall_cycles}, 32'd15);

    // Asynchronous reset from HALTED
    #2 rst = 1'b0;
    step(O_RESET, "async_rst_halted");
    check_val("rst_halted_stall", {16'd0, stall_cycles}, 32'd0);
    check_val("rst_halted_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk); rst = 1'b1;
    step(O_NONE, "after_rst_idle");

    // Asynchronous reset mid-DRAIN
    next_cycle(); id_halt = 1'b1;
    step(O_HOLDPC, "halt2");
    next_cycle();
    step(O_DRAIN, "drain2_1");
    #2 rst = 1'b0;
    step(O_RESET, "async_rst_drain");
    check_val("rst_drain_state", {30'd0, dbg_state}, 32'd0);
    check_val("rst_drain_stall", {16'd0, stall_cycles}, 32'd0);
    check_val("rst_drain_flush", {16'd0, flush_count}, 32'd0);
    @(negedge clk); rst = 1'b1;
    step(O_NONE, "run_after_rst");
    next_cycle();
    step(O_NONE, "run_after_rst_2");
    check_val("stall_after_rel", {16'd0, stall_cycles}, 32'd0);

    // Saturation: 65540 fetch-wait cycles
    for (int i = 0; i < 65540; i++) begin
      next_cycle(); if_busy = 1'b1;
    end
    step(O_HOLDPC, "sat_ifbusy");
    check_val("stall_saturated", {16'd0, stall_cycles}, 32'h0000FFFF);
    next_cycle(); if_busy = 1'b1;
    step(O_HOLDPC, "sat_ifbusy_2");
    check_val("stall_no_wrap", {16'd0, stall_cycles}, 32'h0000FFFF);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It sits directly upstream of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and produces their per-stage hold (freeze) and bubble (load NOP/zero controls) commands. It resolves load-use hazards, taken-branch flushes, multi-cycle I-/D-memory waits, and HLT drain. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: advancing edges from HLT leaving ID until `halted` asserts.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_rs`, `id_rt`  in  4 each  source register numbers of the instruction in ID.
- `id_rs_used`, `id_rt_used`  in  1 each  the ID instruction actually reads that source.
- `idex_rd`  in  4  destination register of the instruction in EX.
- `idex_memread`  in  1  the instruction in EX is a load.
- `id_branch_taken`  in  1  branch resolved taken in ID this cycle.
- `id_halt`  in  1  HLT decoded in ID.
- `if_busy`  in  1  instruction fetch not complete this cycle.
- `mem_busy`  in  1  data access in MEM not complete this cycle.
- `pc_hold`  out  1  PC keeps its value.
- `ifid_hold`, `ifid_bubble`  out  1 each  IF/ID register command.
- `idex_hold`, `idex_bubble`  out  1 each  ID/EX register command.
- `exmem_hold`  out  1  EX/MEM register command.
- `memwb_bubble`  out  1  MEM/WB register command.
- `halted`  out  1  the core is halted; held until reset.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_hold`=1, excluding HALTED.
- `flush_count`  out  CNT_W  count of taken-branch flushes.

## Operation
- Load-use: `load_use` = `idex_memread` & (`idex_rd`≠0) & ((`id_rs_used` & `id_rs`==`idex_rd`) | (`id_rt_used` & `id_rt`==`idex_rd`)). Register 0 never creates a hazard.
- State machine: RUN, DRAIN, HALTED. State register plus a 2-bit drain counter `dcnt` plus a `squash_pending` flag.
- RUN output rules, first match wins. Unlisted outputs are 0.
  1. `mem_busy`: `pc_hold`, `ifid_hold`, `idex_hold`, `exmem_hold`, `memwb_bubble` = 1.
  2. `load_use`: `pc_hold`, `ifid_hold`, `idex_bubble` = 1. Branch and halt are ignored this cycle.
  3. `id_halt`: `pc_hold`, `ifid_bubble` = 1. Next state DRAIN, `dcnt`←DRAIN_CYCLES. Halt wins over a simultaneous branch.
  4. `id_branch_taken`: `ifid_bubble` = 1 and `pc_hold` = 0 (PC loads the target). `flush_count` increments. If `if_busy` is also 1, `squash_pending`←1.
  5. `if_busy`: `pc_hold`, `ifid_bubble` = 1.
  6. `squash_pending` and !`if_busy`: `ifid_bubble` = 1 (the stale wrong-path fetch is discarded). `squash_pending`←0.
- DRAIN:
  - `pc_hold`, `ifid_bubble`, `idex_bubble` = 1.
  - If `mem_busy`: additionally `idex_hold`, `exmem_hold`, `memwb_bubble` = 1, and `dcnt` is held.
  - Otherwise `dcnt` decrements. Move to HALTED on the edge where `dcnt` goes 1→0.
  - `id_halt`, `id_branch_taken` and `if_busy` are ignored.
- HALTED: `halted`=1, `pc_hold`=1, `ifid_bubble`=1, `idex_bubble`=1. All other inputs are ignored. Exit only by reset.
- Counters saturate at all-ones and never wrap. `stall_cycles` increments on every RUN/DRAIN cycle with `pc_hold`=1.

## Timing
- All hold/bubble outputs are combinational from the current inputs and state, valid in the same cycle. The pipeline registers act on the next rising edge.
- Load-use costs exactly one bubble cycle. Branch flush costs one bubble, plus one more if `squash_pending` was set.
- `halted` rises DRAIN_CYCLES non-stalled edges after the edge on which HLT leaves ID.
- While `rst`=0: state RUN, `dcnt`=0, `squash_pending`=0, counters 0, `halted`=0. Outputs are forced to `pc_hold`=1, `ifid_bubble`=`idex_bubble`=`memwb_bubble`=1, all holds 0.
- Reset assertion mid-DRAIN or in HALTED aborts to RUN immediately (asynchronous).

## Structure
- Package `hazard_ctrl_pkg`:
  - enum `ctrl_state_t` {RUN, DRAIN, HALTED}.
  - constant `REG_ADDR_W`=4.
  - constant `ZERO_REG`=4'd0.
- Sub-module `sat_counter`, parameterised width, with increment-enable and async active-low reset. Instantiated twice (`stall_cycles`, `flush_count`).

## Test plan
- Load-use: `idex_memread`=1, `idex_rd`=5, `id_rs`=5, `id_rs_used`=1 for one cycle → `pc_hold`=`ifid_hold`=`idex_bubble`=1 that cycle only; `stall_cycles`=1. With `idex_rd`=0 instead → no stall.
- Branch: `id_branch_taken`=1 with `if_busy`=0 → `ifid_bubble`=1 for one cycle, `pc_hold`=0, `flush_count`=1. With `if_busy`=1 for 3 cycles → `ifid_bubble` on all 3, plus one extra bubble on the first non-busy cycle.
- Memory wait: `mem_busy`=1 for 4 cycles with a simultaneous load-use → the freeze pattern (all holds + `memwb_bubble`) on all 4 cycles; the load-use bubble follows on cycle 5.
- Halt: `id_halt`=1 → DRAIN; `mem_busy`=1 for 2 cycles during DRAIN → `halted` rises after 3+2 edges. `stall_cycles` counts RUN/DRAIN cycles only, then stops.
- Saturation: force 65 540 stall cycles → `stall_cycles`=16'hFFFF, no wrap.
- Reset mid-DRAIN: drop `rst` asynchronously → outputs take reset values before the next edge; after release, state RUN, counters 0.
